button_event_ctrl: RTL

- Consumes the 2-bit press-state code from the per-button debouncer and turns it into clean one-cycle command pulses for the clock's time-setting logic: short press, long press, double click, and hold with auto-repeat.
- One instance per button.
- Sits between the debouncer and the clock mode/set FSM.
- Input code: 2'b11 = released/idle; 2'b10 = short-press release event; 2'b01 = long-press release event; 2'b00 = held past the long limit (level).

---
 rtl/button_event_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/button_event_ctrl.sv
// -----------------------------------------------------------------------------
// button_event_ctrl
//
// Turns the 2-bit press-state code of one debounced button into clean,
// registered command pulses for the clock's time-setting logic.
//
// Input code meaning:
//   2'b11 released / idle
//   2'b10 short-press release event
//   2'b01 long-press release event
//   2'b00 held past the long limit (level)
//
// A code counts as an event only in the first cycle it appears
// (cur != prev). Every output is registered. An event sampled at a clock
// edge shows up in the cycle that follows that edge.
//
// Optional feature macro: DOUBLE_CLICK_EN
//   defined   : after a short press, the block waits up to DBL_WINDOW cycles
//               for a second short press. If one arrives, o_double pulses.
//               Otherwise the delayed o_short pulses.
//   undefined : o_short pulses one cycle after the event. o_double is tied
//               to 0 and the window counter is not built.
//
// Ports:
//   i_clk       system clock, all logic on posedge
//   i_rst_n     synchronous active-low reset
//   i_sw_state  press-state code from the debouncer
//   o_short     one-cycle pulse per accepted short press
//   o_long      one-cycle pulse per long press
//   o_double    one-cycle pulse per double click (0 without DOUBLE_CLICK_EN)
//   o_hold      level, high while the button is in the held state
//   o_repeat    one-cycle auto-repeat pulse while held
// -----------------------------------------------------------------------------
module button_event_ctrl #(
   parameter int unsigned DIV_CONST     = 50_000_000,
   parameter int unsigned REPEAT_PERIOD = DIV_CONST / 5,
   parameter int unsigned DBL_WINDOW    = DIV_CONST / 3
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [1:0] i_sw_state,
   output logic       o_short,
   output logic       o_long,
   output logic       o_double,
   output logic       o_hold,
   output logic       o_repeat
);

   // Both counters run down to 0 and reload from these values.
   localparam logic [31:0] REP_RELOAD = 32'(REPEAT_PERIOD - 1);

   localparam logic [1:0] CODE_IDLE  = 2'b11;
   localparam logic [1:0] CODE_SHORT = 2'b10;
   localparam logic [1:0] CODE_LONG  = 2'b01;
   localparam logic [1:0] CODE_HELD  = 2'b00;

   // Reject periods that would make the reload value 0 or wrap around.
   if (REPEAT_PERIOD < 2 || DBL_WINDOW < 2) begin : g_bad_params
      $error("button_event_ctrl: REPEAT_PERIOD and DBL_WINDOW must be >= 2");
   end

`ifdef DOUBLE_CLICK_EN
   localparam logic [31:0] WIN_RELOAD = 32'(DBL_WINDOW - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT2 = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd2
   } state_t;
`endif

   state_t      state_q, state_d;
   logic [1:0]  prev_q, prev_d;
   logic [31:0] rep_cnt_q, rep_cnt_d;
   logic        short_q, short_d;
   logic        long_q, long_d;
   logic        hold_q, hold_d;
   logic        repeat_q, repeat_d;
   logic        is_new_s;
`ifdef DOUBLE_CLICK_EN
   logic [31:0] win_cnt_q, win_cnt_d;
   logic        double_q, double_d;
`endif

   assign is_new_s = (i_sw_state != prev_q);

   // Next-state and next-output logic of the press FSM.
   always_comb begin
      state_d   = state_q;
      prev_d    = i_sw_state;
      rep_cnt_d = rep_cnt_q;
      short_d   = 1'b0;
      long_d    = 1'b0;
      hold_d    = 1'b0;
      repeat_d  = 1'b0;
`ifdef DOUBLE_CLICK_EN
      win_cnt_d = win_cnt_q;
      double_d  = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (is_new_s && (i_sw_state == CODE_SHORT)) begin
`ifdef DOUBLE_CLICK_EN
               state_d   = ST_WAIT2;
               win_cnt_d = WIN_RELOAD;
`else
               short_d   = 1'b1;
`endif
            end else if (is_new_s && (i_sw_state == CODE_LONG)) begin
               long_d = 1'b1;
            end else if (is_new_s && (i_sw_state == CODE_HELD)) begin
               state_d   = ST_HOLD;
               hold_d    = 1'b1;
               repeat_d  = 1'b1;
               rep_cnt_d = REP_RELOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
`ifdef DOUBLE_CLICK_EN
         ST_WAIT2: begin
            if (is_new_s && (i_sw_state == CODE_SHORT) && (win_cnt_q != 32'd0)) begin
               double_d  = 1'b1;
               state_d   = ST_IDLE;
               win_cnt_d = 32'd0;
            end else if (is_new_s && (i_sw_state == CODE_LONG)) begin
               short_d   = 1'b1;
               long_d    = 1'b1;
               state_d   = ST_IDLE;
               win_cnt_d = 32'd0;
            end else if (is_new_s && (i_sw_state == CODE_HELD)) begin
               short_d   = 1'b1;
               state_d   = ST_HOLD;
               hold_d    = 1'b1;
               repeat_d  = 1'b1;
               rep_cnt_d = REP_RELOAD;
               win_cnt_d = 32'd0;
            end else if (win_cnt_q <= 32'd1) begin
               // The counter reaches 0 at this edge and the window closes.
               short_d   = 1'b1;
               state_d   = ST_IDLE;
               win_cnt_d = 32'd0;
            end else begin
               win_cnt_d = win_cnt_q - 32'd1;
            end
         end
`endif
         ST_HOLD: begin
            if (i_sw_state == CODE_HELD) begin
               hold_d = 1'b1;
               if (rep_cnt_q == 32'd0) begin
                  repeat_d  = 1'b1;
                  rep_cnt_d = REP_RELOAD;
               end else begin
                  rep_cnt_d = rep_cnt_q - 32'd1;
               end
            end else begin
               // Leaving the held state never produces a short or long pulse.
               state_d   = ST_IDLE;
               rep_cnt_d = 32'd0;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            prev_d    = CODE_IDLE;
            rep_cnt_d = 32'd0;
`ifdef DOUBLE_CLICK_EN
            win_cnt_d = 32'd0;
`endif
         end
      endcase
   end

   // State, counter, previous-code and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         prev_q    <= CODE_IDLE;
         rep_cnt_q <= 32'd0;
         short_q   <= 1'b0;
         long_q    <= 1'b0;
         hold_q    <= 1'b0;
         repeat_q  <= 1'b0;
`ifdef DOUBLE_CLICK_EN
         win_cnt_q <= 32'd0;
         double_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         rep_cnt_q <= rep_cnt_d;
         short_q   <= short_d;
         long_q    <= long_d;
         hold_q    <= hold_d;
         repeat_q  <= repeat_d;
`ifdef DOUBLE_CLICK_EN
         win_cnt_q <= win_cnt_d;
         double_q  <= double_d;
`endif
      end
   end

   assign o_short  = short_q;
   assign o_long   = long_q;
   assign o_hold   = hold_q;
   assign o_repeat = repeat_q;
`ifdef DOUBLE_CLICK_EN
   assign o_double = double_q;
`else
   assign o_double = 1'b0;
`endif

endmodule
